// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cpu_pkg
// Brief    : Register-address constants and encoder state type shared by the
//            register-number decoder and the register-mask encoder.
// Revision : 1.0  initial release
// ============================================================================
package cpu_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int NUM_REGS   = 32;
  // One more bit than REG_ADDR_W so a full 32-entry drain fits without wrap.
  localparam int COUNT_W    = REG_ADDR_W + 1;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } enc_state_t;

endpackage
`default_nettype wire

// File: rtl/lowest_set_bit.sv
`default_nettype none
// ============================================================================
// Module   : lowest_set_bit
// Brief    : Combinational priority encoder: index of the lowest set bit,
//            plus nonzero and exactly-one-bit-set flags.
// Revision : 1.0  initial release
// ============================================================================
module lowest_set_bit
  import cpu_pkg::*;
(
  input  logic [NUM_REGS-1:0]   vec,
  output logic [REG_ADDR_W-1:0] index,
  output logic                  any,
  output logic                  single
);

  localparam logic [NUM_REGS-1:0] c_one = {{(NUM_REGS-1){1'b0}}, 1'b1};

  // Scan from the top down so the lowest set bit is the last one written.
  always_comb begin
    index = '0;
    for (int k = NUM_REGS - 1; k >= 0; k--) begin
      if (vec[k]) begin
        index = REG_ADDR_W'(k);
      end
    end
  end

  assign any    = |vec;
  // Clearing the lowest set bit leaves zero only when one bit was set.
  assign single = any && ((vec & (vec - c_one)) == '0);

endmodule
`default_nettype wire

// File: rtl/regmask_encoder.sv
`default_nettype none
// ============================================================================
// Module   : regmask_encoder
// Brief    : Turns a 32-bit register mask into a stream of register numbers,
//            lowest first, one per output handshake; pulses done with the
//            number of entries when the mask is drained.
// Revision : 1.0  initial release
// ============================================================================
module regmask_encoder
  import cpu_pkg::*;
#(
  parameter bit SKIP_X0 = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [NUM_REGS-1:0]   in_mask,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [REG_ADDR_W-1:0] out_regnum,
  output logic                  out_last,
  output logic                  done,
  output logic [COUNT_W-1:0]    done_count
);

  localparam logic [NUM_REGS-1:0] c_one_mask  = {{(NUM_REGS-1){1'b0}}, 1'b1};
  localparam logic [COUNT_W-1:0]  c_one_count = {{(COUNT_W-1){1'b0}}, 1'b1};
  // Bit 0 is dropped at capture when x0 is excluded from the stream.
  localparam logic [NUM_REGS-1:0] c_x0_clear  = ~{{(NUM_REGS-1){1'b0}}, SKIP_X0};

  enc_state_t              r_state;
  enc_state_t              w_state_next;
  logic [NUM_REGS-1:0]     r_pending;
  logic [COUNT_W-1:0]      r_count;
  logic                    r_done;
  logic [COUNT_W-1:0]      r_done_count;

  logic [NUM_REGS-1:0]     w_eff_mask;
  logic                    w_eff_empty;
  logic                    w_in_fire;
  logic                    w_out_fire;
  logic [REG_ADDR_W-1:0]   w_lsb_index;
  logic                    w_lsb_any;
  logic                    w_lsb_single;

  lowest_set_bit u_lsb (
    .vec    (r_pending),
    .index  (w_lsb_index),
    .any    (w_lsb_any),
    .single (w_lsb_single)
  );

  assign w_eff_mask  = in_mask & c_x0_clear;
  assign w_eff_empty = (w_eff_mask == '0);
  assign w_in_fire   = in_valid && in_ready;
  assign w_out_fire  = out_valid && out_ready;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next state: empty masks never leave IDLE; BUSY ends on the last handshake.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE: if (w_in_fire && !w_eff_empty) w_state_next = BUSY;
      BUSY: if (w_out_fire && out_last)    w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // Outputs decoded from state and pending; in_ready is held low during reset.
  always_comb begin
    in_ready   = (r_state == IDLE) && !rst;
    out_valid  = (r_state == BUSY);
    out_regnum = (r_state == BUSY) ? w_lsb_index : '0;
    out_last   = (r_state == BUSY) && w_lsb_single;
  end

  // Pending bits and entry count: load on capture, retire lowest bit per handshake.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pending <= '0;
      r_count   <= '0;
    end else if (w_in_fire) begin
      r_pending <= w_eff_mask;
      r_count   <= '0;
    end else if (w_out_fire) begin
      r_pending <= r_pending & (r_pending - c_one_mask);
      r_count   <= r_count + c_one_count;
    end
  end

  // Completion pulse one cycle after the final handshake or an empty capture.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_done       <= 1'b0;
      r_done_count <= '0;
    end else begin
      r_done <= (w_in_fire && w_eff_empty) || (w_out_fire && out_last);
      if (w_in_fire && w_eff_empty) begin
        r_done_count <= '0;
      end else if (w_out_fire && out_last) begin
        r_done_count <= r_count + c_one_count;
      end
    end
  end

  assign done       = r_done;
  assign done_count = r_done_count;

endmodule
`default_nettype wire
